dm_access_scheduler: RTL and testbench

//  Shares one single-port data SRAM between a read requester and a write requester
//  (both are AXI slave-side front ends).
//  - Arbitrates round-robin between the two; a grant holds for the whole burst.
//  - Sequences CS/OE/WEB/A/DI; captures DO one cycle after each read issue.
//  - Sits between the AXI slave protocol logic and the SRAM macro.

---
 rtl/dm_sched_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/dm_access_scheduler.sv | 137 +++++++++++++
 tb/tb_dm_access_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_sched_pkg.sv
// Shared types for the data-SRAM access scheduler: FSM states, grant owner, idle strobe level.
package dm_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAP,
    RD_DATA,
    WR_BEAT,
    WR_RESP
  } sched_state_e;

  typedef enum logic {
    GNT_RD,
    GNT_WR
  } grant_e;

  // Per-bit level of the active-low byte write enable when nothing is written.
  localparam logic WEB_IDLE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last_grant advances only on a taken grant.
module rr_arb2
  import dm_sched_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   req_rd,
  input  logic   req_wr,
  output logic   gnt_vld,
  output grant_e gnt
);

  grant_e last_grant;

  always_comb begin
    gnt_vld = en && (req_rd || req_wr);
    if (req_rd && req_wr) begin
      gnt = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
    end else if (req_rd) begin
      gnt = GNT_RD;
    end else begin
      gnt = GNT_WR;
    end
  end

  // Reset to WR so a read wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GNT_WR;
    end else if (gnt_vld) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/dm_access_scheduler.sv
// Shares one single-port SRAM between a read and a write burst requester; grants hold per burst.
// Read beats take 3 cycles minimum (issue, capture, present); write beats stream one per cycle.
module dm_access_scheduler
  import dm_sched_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              rd_last,
  input  logic              rd_data_ready,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_ack,
  input  logic              wr_beat_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              wr_last,
  output logic              wr_beat_ready,
  output logic              wr_done,
  output logic              wr_err,
  output logic              CS,
  output logic              OE,
  output logic [STRB_W-1:0] WEB,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] DI,
  input  logic [DATA_W-1:0] DO
);

  sched_state_e      state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic              err;
  logic              arb_en;
  logic              gnt_vld;
  grant_e            gnt;
  logic              cnt_end;
  logic              wr_fire;

  assign arb_en = (state == IDLE) && !ARESET;

  rr_arb2 u_arb (
    .clk     (ACLK),
    .reset   (ARESET),
    .en      (arb_en),
    .req_rd  (rd_req),
    .req_wr  (wr_req),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  assign cnt_end       = (cnt == len);
  assign wr_fire       = (state == WR_BEAT) && wr_beat_valid;
  assign rd_ack        = gnt_vld && (gnt == GNT_RD);
  assign wr_ack        = gnt_vld && (gnt == GNT_WR);
  assign rd_data_valid = (state == RD_DATA);
  assign rd_last       = rd_data_valid && cnt_end;
  assign wr_beat_ready = (state == WR_BEAT);
  assign wr_done       = (state == WR_RESP);
  assign wr_err        = wr_done && err;

  // SRAM pins follow state directly, so reset forces them idle without extra gating.
  always_comb begin
    CS  = (state == RD_ISSUE) || wr_fire;
    OE  = (state == RD_ISSUE);
    WEB = wr_fire ? ~wr_strb : {STRB_W{WEB_IDLE}};
    A   = CS ? cur_addr : '0;
    DI  = wr_fire ? wr_data : '0;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      cur_addr <= '0;
      len      <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            cur_addr <= (gnt == GNT_RD) ? rd_addr : wr_addr;
            len      <= (gnt == GNT_RD) ? rd_len : wr_len;
            cnt      <= '0;
            err      <= 1'b0;
            state    <= (gnt == GNT_RD) ? RD_ISSUE : WR_BEAT;
          end
        end
        RD_ISSUE: state <= RD_CAP;
        RD_CAP: begin
          rd_data <= DO;
          state   <= RD_DATA;
        end
        RD_DATA: begin
          if (rd_data_ready) begin
            if (cnt_end) begin
              state <= IDLE;
            end else begin
              cur_addr <= cur_addr + ADDR_W'(1);
              cnt      <= cnt + LEN_W'(1);
              state    <= RD_ISSUE;
            end
          end
        end
        WR_BEAT: begin
          // The beat counter alone ends the burst; wr_last is only cross-checked.
          if (wr_beat_valid) begin
            if (wr_last != cnt_end) begin
              err <= 1'b1;
            end
            if (cnt_end) begin
              state <= WR_RESP;
            end else begin
              cur_addr <= cur_addr + ADDR_W'(1);
              cnt      <= cnt + LEN_W'(1);
            end
          end
        end
        WR_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_scheduler.sv
// Randomized bench for dm_access_scheduler: SRAM behavioural model plus word-array reference memory.
module tb_dm_access_scheduler;

  logic        ACLK;
  logic        ARESET;
  logic        rd_req;
  logic [13:0] rd_addr;
  logic [3:0]  rd_len;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        rd_last;
  logic        rd_data_ready;
  logic        wr_req;
  logic [13:0] wr_addr;
  logic [3:0]  wr_len;
  logic        wr_ack;
  logic        wr_beat_valid;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_last;
  logic        wr_beat_ready;
  logic        wr_done;
  logic        wr_err;
  logic        CS;
  logic        OE;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI;
  logic [31:0] DO = '0;

  dm_access_scheduler dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_last(rd_last),
    .rd_data_ready(rd_data_ready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
    .wr_beat_valid(wr_beat_valid), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_last(wr_last), .wr_beat_ready(wr_beat_ready), .wr_done(wr_done),
    .wr_err(wr_err),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [13:0] a);
    if (a == 14'h10) return 32'hDEADBEEF;
    return (32'h9E3779B9 * {18'b0, a}) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] web);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (!web[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // SRAM macro model: DO registered one cycle after CS&OE, byte writes on CS&!OE.
  logic [31:0] mem [0:16383];
  bit          wrt [0:16383];
  always @(posedge ACLK) begin
    if (CS && OE) DO <= wrt[A] ? mem[A] : init_val(A);
    if (CS && !OE) begin
      mem[A] <= merge(wrt[A] ? mem[A] : init_val(A), DI, WEB);
      wrt[A] <= 1'b1;
    end
  end

  logic [31:0] ref_mem [0:16383];
  bit          model_last_wr;
  int          rd_ack_c;
  int          wr_ack_c;
  bit          ok0;

  task automatic wait_ack(input bit is_rd, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge ACLK);
      if (is_rd ? rd_ack : wr_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_read(input logic [13:0] addr, input logic [3:0] len, input int rdy_pct);
    bit ok;
    int waits;
    logic [13:0] a;
    @(posedge ACLK); #1;
    rd_addr = addr; rd_len = len; rd_req = 1'b1;
    wait_ack(1'b1, ok);
    if (!ok) begin
      chk("rd_ack_timeout", 0, 1);
      @(posedge ACLK); #1 rd_req = 1'b0;
      return;
    end
    rd_ack_c = cyc;
    @(posedge ACLK); #1 rd_req = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 14'(i);
      @(negedge ACLK);
      chk("rd_issue_pins", {CS, OE, A}, {2'b11, a});
      @(negedge ACLK);
      chk("rd_cap_novalid", rd_data_valid, 0);
      @(posedge ACLK); #1 rd_data_ready = ($urandom_range(99) < rdy_pct);
      @(negedge ACLK);
      if (i == 0) chk("rd_latency", 64'(cyc - rd_ack_c), 3);
      waits = 0;
      while (1) begin
        chk("rd_valid", rd_data_valid, 1);
        chk("rd_data", rd_data, ref_mem[a]);
        chk("rd_last", rd_last, (i == int'(len)));
        if (rd_data_ready) break;
        @(posedge ACLK); #1 rd_data_ready = (waits >= 5) || ($urandom_range(99) < rdy_pct);
        waits++;
        @(negedge ACLK);
      end
      @(posedge ACLK); #1 rd_data_ready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [13:0] addr, input logic [3:0] len, input int vld_pct,
                          input int gap, input logic [15:0] last_mask, input bit rnd_strb,
                          input logic [3:0] strb_fix);
    bit ok, exp_err, v;
    int gaps, fg;
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    @(posedge ACLK); #1;
    wr_addr = addr; wr_len = len; wr_req = 1'b1;
    wait_ack(1'b0, ok);
    if (!ok) begin
      chk("wr_ack_timeout", 0, 1);
      @(posedge ACLK); #1 wr_req = 1'b0;
      return;
    end
    wr_ack_c = cyc;
    @(posedge ACLK); #1 wr_req = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 14'(i);
      gaps = 0;
      fg = (i > 0) ? gap : 0;
      while (1) begin
        v = (gaps >= fg) && ((gaps >= fg + 4) || ($urandom_range(99) < vld_pct));
        d = $urandom;
        s = rnd_strb ? 4'($urandom) : strb_fix;
        wr_beat_valid = v; wr_data = d; wr_strb = s; wr_last = last_mask[i];
        @(negedge ACLK);
        chk("wr_ready", wr_beat_ready, 1);
        if (v) begin
          chk("wr_beat_pins", {CS, OE, WEB, A}, {1'b1, 1'b0, ~s, a});
          chk("wr_beat_di", DI, d);
          for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
          if (last_mask[i] != (i == int'(len))) exp_err = 1'b1;
          @(posedge ACLK); #1 wr_beat_valid = 1'b0;
          break;
        end
        chk("wr_gap_pins", {CS, WEB}, {1'b0, 4'hF});
        gaps++;
        @(posedge ACLK); #1;
      end
    end
    @(negedge ACLK);
    chk("wr_done", wr_done, 1);
    chk("wr_err", wr_err, exp_err);
  endtask

  // Both requesters raised in the same cycle: the side not granted most recently wins.
  task automatic run_tie(input logic [13:0] raddr, input logic [3:0] rlen,
                         input logic [13:0] waddr, input logic [3:0] wlen, input int wgap,
                         input logic [15:0] wmask, input bit rnd_strb, input logic [3:0] strb_fix);
    bit exp_rd_first;
    exp_rd_first = model_last_wr;
    fork
      do_read(raddr, rlen, 70);
      do_write(waddr, wlen, 100, wgap, wmask, rnd_strb, strb_fix);
    join
    chk("tie_order_rd_first", (rd_ack_c < wr_ack_c), exp_rd_first);
    model_last_wr = exp_rd_first;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    logic [13:0] ra, wa;
    logic [3:0]  rl, wl;
    logic [15:0] mask;
    for (int k = 0; k < 16384; k++) ref_mem[k] = init_val(14'(k));
    ARESET = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = '0; rd_len = '0; rd_data_ready = 1'b0;
    wr_addr = '0; wr_len = '0; wr_beat_valid = 1'b0; wr_data = '0; wr_strb = '0; wr_last = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_sram_pins", {CS, OE, WEB, A}, {1'b0, 1'b0, 4'hF, 14'h0});
    chk("rst_di", DI, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_handshakes", {rd_ack, wr_ack, rd_data_valid, rd_last, wr_beat_ready, wr_done, wr_err}, 0);
    @(posedge ACLK); #1;
    rd_req = 1'b0; wr_req = 1'b0; ARESET = 1'b0;
    model_last_wr = 1'b1;

    run_tie(14'h10, 4'h0, 14'h20, 4'h3, 0, 16'h0008, 1'b0, 4'hF);
    run_tie(14'h3FFF, 4'h1, 14'h40, 4'h1, 2, 16'h0001, 1'b1, 4'h0);
    do_read(14'h20, 4'h3, 100);
    model_last_wr = 1'b0;
    do_write(14'h21, 4'h0, 100, 0, 16'h0001, 1'b0, 4'h0);
    model_last_wr = 1'b1;
    do_read(14'h21, 4'h0, 100);
    model_last_wr = 1'b0;
    run_tie(14'h3FFE, 4'h2, 14'h3FFD, 4'h4, 1, 16'h0010, 1'b1, 4'h0);

    // Reset while a read beat is being presented and not accepted.
    @(posedge ACLK); #1;
    rd_addr = 14'h5; rd_len = 4'h2; rd_req = 1'b1; rd_data_ready = 1'b0;
    wait_ack(1'b1, ok0);
    chk("mr_ack", ok0, 1);
    @(posedge ACLK); #1 rd_req = 1'b0;
    ok0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      if (rd_data_valid) begin ok0 = 1'b1; break; end
    end
    chk("mr_valid_seen", ok0, 1);
    @(posedge ACLK); #1 ARESET = 1'b1;
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("mr_pins_idle", {CS, OE, WEB}, {1'b0, 1'b0, 4'hF});
    chk("mr_outputs", {rd_data_valid, rd_last, wr_beat_ready, wr_done, rd_ack, wr_ack}, 0);
    chk("mr_rd_data", rd_data, 0);
    model_last_wr = 1'b1;
    run_tie(14'h100, 4'h1, 14'h101, 4'h2, 0, 16'h0004, 1'b1, 4'h0);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(2);
      ra = ($urandom_range(3) == 0) ? 14'h3FF8 + 14'($urandom_range(7)) : 14'($urandom);
      wa = ($urandom_range(1) == 0) ? ra + 14'($urandom_range(3)) : 14'($urandom);
      rl = 4'($urandom);
      wl = 4'($urandom);
      mask = 16'h0001 << wl;
      if ($urandom_range(3) == 0) mask = mask ^ (16'h0001 << $urandom_range(15));
      case (kind)
        0: begin
          do_read(ra, rl, 20 + $urandom_range(80));
          model_last_wr = 1'b0;
        end
        1: begin
          do_write(wa, wl, 30 + $urandom_range(70), $urandom_range(2), mask, 1'b1, 4'h0);
          model_last_wr = 1'b1;
        end
        default: run_tie(ra, rl, wa, wl, $urandom_range(2), mask, 1'b1, 4'h0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
